// File: rtl/parent_link_hub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parent_link_hub_pkg
// Description : Shared definitions for the root-side parent-link hub and the
//               root controller: destination-ID field, FSM encoding, msg types.
// Revision    : 1.0 - initial release
// ============================================================================
package parent_link_hub_pkg;

    localparam int          DEF_NUM_CHILDREN = 4;
    localparam int          DEF_WIDTH        = 64;
    localparam int          DEST_ID_W        = 8;
    localparam logic [7:0]  PKG_BROADCAST_ID = 8'hFF;

    typedef enum logic [1:0] {
        DOWN_IDLE  = 2'd0,
        DOWN_UNI   = 2'd1,
        DOWN_BCAST = 2'd2
    } down_state_e;

    typedef enum logic [3:0] {
        MSG_NOP    = 4'h0,
        MSG_DATA   = 4'h1,
        MSG_CTRL   = 4'h2,
        MSG_STATUS = 4'h3
    } msg_type_e;

    // The destination ID always occupies the top DEST_ID_W bits of a word.
    function automatic int dest_lsb(input int width);
        return width - DEST_ID_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parent_link_hub_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; grants the first requester at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [PTR_W:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            // Wrap ptr+i back into 0..N-1 without relying on power-of-two N.
            cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(N)) begin
                cand = cand - (PTR_W+1)'(N);
            end
            if (en && !grant_valid && req[cand[PTR_W-1:0]]) begin
                grant[cand[PTR_W-1:0]] = 1'b1;
                grant_idx              = cand[PTR_W-1:0];
                grant_valid            = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/parent_link_hub.sv
`default_nettype none
// ============================================================================
// Module      : parent_link_hub
// Description : Merges leaf-FPGA upstream words round-robin to the root
//               controller; routes root words to one child or broadcasts.
// Revision    : 1.0 - initial release
// ============================================================================
module parent_link_hub
    import parent_link_hub_pkg::*;
#(
    parameter int                  NUM_CHILDREN = DEF_NUM_CHILDREN,
    parameter int                  WIDTH        = DEF_WIDTH,
    parameter int                  ID_WIDTH     = DEST_ID_W,
    parameter logic [ID_WIDTH-1:0] BROADCAST_ID = PKG_BROADCAST_ID
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CHILDREN*WIDTH-1:0] child_rx_data,
    input  logic [NUM_CHILDREN-1:0]       child_rx_valid,
    output logic [NUM_CHILDREN-1:0]       child_rx_ready,
    output logic [NUM_CHILDREN*WIDTH-1:0] child_tx_data,
    output logic [NUM_CHILDREN-1:0]       child_tx_valid,
    input  logic [NUM_CHILDREN-1:0]       child_tx_ready,
    output logic [WIDTH-1:0]              up_data,
    output logic                          up_valid,
    input  logic                          up_ready,
    input  logic [WIDTH-1:0]              down_data,
    input  logic                          down_valid,
    output logic                          down_ready,
    output logic                          busy,
    output logic                          err_bad_dest
);

    localparam int PTR_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;

    logic [WIDTH-1:0]        up_data_q, up_data_d;
    logic                    up_valid_q, up_valid_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    load;
    logic [NUM_CHILDREN-1:0] grant;
    logic [PTR_W-1:0]        grant_idx;
    logic                    grant_valid;

    down_state_e             state_q, state_d;
    logic [NUM_CHILDREN-1:0] mask_q, mask_d;
    logic [WIDTH-1:0]        tx_data_q, tx_data_d;
    logic                    err_q, err_d;
    logic [ID_WIDTH-1:0]     dest;
    logic [NUM_CHILDREN-1:0] dest_onehot;

    // Output register refills whenever it is empty or draining this cycle.
    assign load = !up_valid_q || up_ready;

    rr_arbiter #(
        .N     (NUM_CHILDREN),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req         (child_rx_valid),
        .en          (load && !reset),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        up_valid_d = up_valid_q;
        up_data_d  = up_data_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            up_valid_d = grant_valid;
            if (grant_valid) begin
                up_data_d = child_rx_data[int'(grant_idx)*WIDTH +: WIDTH];
                rr_ptr_d  = (grant_idx == PTR_W'(NUM_CHILDREN-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign dest = down_data[WIDTH-1 -: ID_WIDTH];

    always_comb begin
        dest_onehot = '0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            dest_onehot[k] = (dest == ID_WIDTH'(k+1));
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        tx_data_d = tx_data_q;
        err_d     = err_q;
        case (state_q)
            DOWN_IDLE: begin
                if (down_valid) begin
                    if (dest == BROADCAST_ID) begin
                        state_d   = DOWN_BCAST;
                        mask_d    = '1;
                        tx_data_d = down_data;
                    end else if (|dest_onehot) begin
                        state_d   = DOWN_UNI;
                        mask_d    = dest_onehot;
                        tx_data_d = down_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                // Children retire independently; done once every pending bit clears.
                mask_d = mask_q & ~child_tx_ready;
                if (mask_d == '0) begin
                    state_d = DOWN_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            up_valid_q <= 1'b0;
            up_data_q  <= '0;
            rr_ptr_q   <= '0;
            state_q    <= DOWN_IDLE;
            mask_q     <= '0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            up_valid_q <= up_valid_d;
            up_data_q  <= up_data_d;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= state_d;
            mask_q     <= mask_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    assign child_rx_ready = grant;
    assign up_valid       = up_valid_q;
    assign up_data        = up_data_q;
    assign child_tx_valid = mask_q;
    assign child_tx_data  = {NUM_CHILDREN{tx_data_q}};
    assign down_ready     = (state_q == DOWN_IDLE) && !reset;
    assign busy           = up_valid_q || (state_q != DOWN_IDLE);
    assign err_bad_dest   = err_q;

endmodule
`default_nettype wire
